product_accumulator: RTL



---
 rtl/mac_pkg.sv | 13 +
 rtl/product_sat_adder.sv | 21 ++
 rtl/product_accumulator.sv | 88 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath stages.
package mac_pkg;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam int unsigned DEF_PROD_W    = 8;
  localparam int unsigned DEF_ACC_W     = 10;
  localparam int unsigned DEF_MAX_TERMS = 16;

endpackage

// File: rtl/product_sat_adder.sv
// Unsigned saturating add of a PROD_W operand onto an ACC_W accumulator.
module product_sat_adder
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] full;

  // Extra top bit captures the carry-out that marks saturation.
  assign full = {1'b0, acc} + (ACC_W+1)'(addend);
  assign sat  = full[ACC_W];
  assign sum  = sat ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a frame of multiplier products into a saturating sum and hands the result downstream.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W    = DEF_PROD_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned MAX_TERMS = DEF_MAX_TERMS,
  parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_count,
  output logic              overflow
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             sat;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             ovf;
  logic             accept;
  logic             close;

  product_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc    (acc),
    .addend (product),
    .sum    (acc_next),
    .sat    (sat)
  );

  assign in_ready  = (state == ST_ACC) && !clr;
  assign accept    = in_valid && in_ready;
  assign count_inc = count + 1'b1;
  assign close     = accept && (in_last || (count_inc == CNT_W'(MAX_TERMS)));

  // Result registers double as the running state; no beats arrive in OUT so they hold.
  assign out_valid  = (state == ST_OUT);
  assign acc_out    = acc;
  assign term_count = count;
  assign overflow   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (clr) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (accept) begin
            acc   <= acc_next;
            count <= count_inc;
            ovf   <= ovf | sat;
            if (close) state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
